demosaic_cfa_param: RTL
=======================

Name: demosaic_cfa_param

Overview:
- Parametrised successor to the fixed 8-bit, fixed-pattern bilinear demosaic engine.
- Loads a raw Bayer frame from image memory and scatters each sample into three per-channel frame memories (R/G/B).
- Fills every missing colour sample by bilinear interpolation.
- Adds run-time CFA pattern select, parametrised pixel width and frame size, mirrored border handling, a start/busy handshake and an error pulse.

Parameters:
DATA_W, 8, pixel bit width (4..16)
MAX_W, 512, maximum frame width in pixels
MAX_H, 256, maximum frame height in pixels
W_BITS, 10, width port bits (must hold MAX_W)
H_BITS, 9, height port bits (must hold MAX_H)
ADDR_W, 17, memory address bits (must hold MAX_W*MAX_H-1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle start request; accepted only in IDLE
pattern  in  2  CFA layout: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR; latched with start
width  in  W_BITS  frame width; latched with start
height  in  H_BITS  frame height; latched with start
busy  out  1  high from the cycle after an accepted start through the DONE cycle
img_addr  out  ADDR_W  raw image read address
img_rdata  in  DATA_W  raw sample; combinational read, valid in the same cycle as img_addr
wr_r/wr_g/wr_b  out  1  per-channel write enable
addr_r/addr_g/addr_b  out  ADDR_W  per-channel address (shared by read and write)
wdata_r/wdata_g/wdata_b  out  DATA_W  per-channel write data
rdata_r/rdata_g/rdata_b  in  DATA_W  per-channel combinational read data
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse: start rejected because width<2 or height<2

Behaviour:
- Reset: state IDLE; all counters and accumulators 0. busy, done, err and all wr_* are 0; all addresses are 0.
- Reset asserted mid-frame aborts immediately; there is no resume.
- Pixel index: n = y*W + x, row-major, 0..N-1 with N = W*H.
- CFA phase: p = {y[0]^pattern[1], x[0]^pattern[0]}.
  - 00 = R site; 01 = G site in an R row; 10 = G site in a B row; 11 = B site.
- States: IDLE, LOAD, INTERP, SAVE, DONE.
- IDLE:
  - start with W>=2 and H>=2 -> LOAD; width, height and pattern are latched.
  - start with W<2 or H<2 -> stay in IDLE, pulse err for 1 cycle.
  - start while not in IDLE is ignored.
- LOAD (N cycles, one pixel per cycle):
  - img_addr = n.
  - Only the native channel of the site is written: wr = 1, addr = n, wdata = img_rdata.
  - After n = N-1 -> INTERP with n = 0.
- INTERP (4 cycles per pixel, tap k = 0..3):
  - Every cycle, each channel is read at its tap address and rdata is added into a (DATA_W+2)-bit accumulator.
  - Native channel: all 4 taps address n itself (value discarded).
  - Taps for a 4-neighbour channel: up, left, right, down for the orthogonal set; UL, UR, DL, DR for the diagonal set.
  - Taps for a 2-neighbour channel: a, b, a, b.
  - R site: G = orthogonal, B = diagonal.
  - B site: G = orthogonal, R = diagonal.
  - p=01: R = left/right, B = up/down.
  - p=10: R = up/down, B = left/right.
- Borders use mirror reflection, which preserves channel parity:
  - x-1 at x=0 -> x=1; x+1 at x=W-1 -> x=W-2.
  - y-1 at y=0 -> y=1; y+1 at y=H-1 -> y=H-2.
  - No address may ever fall outside 0..N-1.
- SAVE (1 cycle per pixel):
  - The two missing channels are written with wr = 1, addr = n, wdata = acc>>2 (floor, no rounding).
  - The native channel has wr = 0. All accumulators clear.
  - n = N-1 -> DONE; otherwise n+1 -> INTERP.
- DONE: done = 1 for 1 cycle, then IDLE.
- Total latency, start accept to done: N + 5N + 1 cycles.
- Write data is always exactly DATA_W bits; the accumulator cannot overflow (4 * (2^DATA_W - 1) fits in DATA_W+2 bits).
- All address arithmetic is ADDR_W bits wide with no wrap.

Test Plan:
- 4x4, pattern 0, img[n] = 16*n (8-bit) -> done at cycle 97.
  - Pixel (1,1) is a B site, n=5: R = (0+32+128+160)>>2 = 80, G = (16+64+96+144)>>2 = 80; wr_b = 0 at SAVE.
- Same frame with pattern 3 -> pixel (0,0) is a B site.
  - G = mirrored (16+16+64+64)>>2 = 40; R = (1,1) value 80 four times = 80.
- 2x2 minimum frame, pattern 1, img = {10,20,30,40}:
  - Loaded R(1,0) = 20 in LOAD; R(0,0) = 20; B(1,0) = 30.
  - err = 0; done after 2x2 frame latency (4 + 20 + 1 = 25 cycles).
- start with width = 1 -> err pulse for 1 cycle, busy stays 0, no wr_* activity.
- Reset and restart:
  - reset_n low during INTERP of pixel 7 -> all outputs 0 next edge, state IDLE.
  - Fresh start produces the full correct frame.
- start pulsed while busy -> ignored; pattern change mid-frame has no effect.
- DATA_W = 12 build, all samples 4095 -> every write is 4095, no overflow.

Source files
------------

// File: rtl/demosaic_cfa_param.sv
// demosaic_cfa_param
//   Bilinear Bayer demosaic engine with a CFA pattern chosen at run time,
//   a parametrised pixel width and frame size, and mirrored borders.
//   It loads a raw frame from image memory and scatters each sample into
//   the R/G/B frame memory of its native channel. It then fills every
//   missing colour sample from four taps, each read from that colour's
//   frame memory.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; bad dimensions pulse err
//   LOAD   | one raw sample per cycle copied to its native channel
//   INTERP | 4 tap cycles per pixel, every channel accumulates
//   SAVE   | missing channels written with acc>>2, accumulators cleared
//   DONE   | one-cycle done pulse
//
// Ports
//   clk, reset_n                  clock, async active-low reset
//   start, pattern, width, height start request and frame setup (latched)
//   busy, done, err               status: busy, completion pulse, reject pulse
//   img_addr / img_rdata          raw image memory (combinational read)
//   wr_*, addr_*, wdata_*, rdata_* per-channel frame memory (shared address)

module demosaic_cfa_param #(
    parameter int DATA_W = 8,
    parameter int MAX_W  = 512,
    parameter int MAX_H  = 256,
    parameter int W_BITS = 10,
    parameter int H_BITS = 9,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        pattern,
    input  logic [W_BITS-1:0] width,
    input  logic [H_BITS-1:0] height,
    output logic              busy,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [DATA_W-1:0] img_rdata,
    output logic              wr_r,
    output logic              wr_g,
    output logic              wr_b,
    output logic [ADDR_W-1:0] addr_r,
    output logic [ADDR_W-1:0] addr_g,
    output logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] wdata_r,
    output logic [DATA_W-1:0] wdata_g,
    output logic [DATA_W-1:0] wdata_b,
    input  logic [DATA_W-1:0] rdata_r,
    input  logic [DATA_W-1:0] rdata_g,
    input  logic [DATA_W-1:0] rdata_b,
    output logic              done,
    output logic              err
);

    if (DATA_W < 4 || DATA_W > 16 || MAX_W >= (1 << W_BITS) ||
        MAX_H >= (1 << H_BITS) || MAX_W * MAX_H > (1 << ADDR_W)) begin : g_bad_param
        $error("demosaic_cfa_param: inconsistent parameters");
    end

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_INTERP, S_SAVE, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t              state, state_nx;
    logic [W_BITS-1:0]   w_q, x;
    logic [H_BITS-1:0]   h_q, y;
    logic [1:0]          pat_q, k;
    logic [ADDR_W-1:0]   n;
    logic [DATA_W+1:0]   acc_r, acc_g, acc_b;
    logic                err_q;

    logic                dims_ok, x_first, x_last, y_first, y_last, pix_last;
    logic [1:0]          phase;
    logic                nat_r, nat_g, nat_b;
    logic [ADDR_W-1:0]   w_a, a_u, a_d, a_l, a_r, a_ul, a_ur, a_dl, a_dr;
    logic [ADDR_W-1:0]   t_orth, t_diag, t_lr, t_ud, tap_r, tap_g, tap_b;

    assign dims_ok  = (width >= W_BITS'(2)) && (height >= H_BITS'(2));
    assign x_first  = (x == '0);
    assign y_first  = (y == '0);
    assign x_last   = (x == w_q - W_BITS'(1));
    assign y_last   = (y == h_q - H_BITS'(1));
    assign pix_last = x_last && y_last;

    assign phase = {y[0] ^ pat_q[1], x[0] ^ pat_q[0]};
    assign nat_r = (phase == 2'b00);
    assign nat_b = (phase == 2'b11);
    assign nat_g = phase[1] ^ phase[0];

    // Mirror reflection expressed as address offsets: a missing row/column
    // neighbour on the border is replaced by the one on the opposite side,
    // so the sum never leaves the frame and never wraps.
    always_comb begin
        w_a  = ADDR_W'(w_q);
        a_u  = y_first ? n + w_a : n - w_a;
        a_d  = y_last  ? n - w_a : n + w_a;
        a_l  = x_first ? n + ONE : n - ONE;
        a_r  = x_last  ? n - ONE : n + ONE;
        a_ul = x_first ? a_u + ONE : a_u - ONE;
        a_ur = x_last  ? a_u - ONE : a_u + ONE;
        a_dl = x_first ? a_d + ONE : a_d - ONE;
        a_dr = x_last  ? a_d - ONE : a_d + ONE;
        case (k)
            2'd0:    begin t_orth = a_u; t_diag = a_ul; end
            2'd1:    begin t_orth = a_l; t_diag = a_ur; end
            2'd2:    begin t_orth = a_r; t_diag = a_dl; end
            default: begin t_orth = a_d; t_diag = a_dr; end
        endcase
        t_lr = k[0] ? a_r : a_l;
        t_ud = k[0] ? a_d : a_u;
        case (phase)
            2'b00:   begin tap_r = n;      tap_g = t_orth; tap_b = t_diag; end
            2'b11:   begin tap_r = t_diag; tap_g = t_orth; tap_b = n;      end
            2'b01:   begin tap_r = t_lr;   tap_g = n;      tap_b = t_ud;   end
            default: begin tap_r = t_ud;   tap_g = n;      tap_b = t_lr;   end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start && dims_ok) state_nx = S_LOAD;
            S_LOAD:   if (pix_last) state_nx = S_INTERP;
            S_INTERP: if (k == 2'd3) state_nx = S_SAVE;
            S_SAVE:   state_nx = pix_last ? S_DONE : S_INTERP;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        err      = err_q;
        img_addr = '0;
        addr_r   = '0;
        addr_g   = '0;
        addr_b   = '0;
        wr_r     = 1'b0;
        wr_g     = 1'b0;
        wr_b     = 1'b0;
        wdata_r  = '0;
        wdata_g  = '0;
        wdata_b  = '0;
        case (state)
            S_LOAD: begin
                img_addr = n;
                addr_r   = n;
                addr_g   = n;
                addr_b   = n;
                wr_r     = nat_r;
                wr_g     = nat_g;
                wr_b     = nat_b;
                if (nat_r) wdata_r = img_rdata;
                if (nat_g) wdata_g = img_rdata;
                if (nat_b) wdata_b = img_rdata;
            end
            S_INTERP: begin
                addr_r = tap_r;
                addr_g = tap_g;
                addr_b = tap_b;
            end
            S_SAVE: begin
                addr_r = n;
                addr_g = n;
                addr_b = n;
                wr_r   = !nat_r;
                wr_g   = !nat_g;
                wr_b   = !nat_b;
                if (!nat_r) wdata_r = acc_r[DATA_W+1:2];
                if (!nat_g) wdata_g = acc_g[DATA_W+1:2];
                if (!nat_b) wdata_b = acc_b[DATA_W+1:2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_q   <= '0;
            h_q   <= '0;
            pat_q <= '0;
            x     <= '0;
            y     <= '0;
            n     <= '0;
            k     <= '0;
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    if (dims_ok) begin
                        w_q   <= width;
                        h_q   <= height;
                        pat_q <= pattern;
                        x     <= '0;
                        y     <= '0;
                        n     <= '0;
                        k     <= '0;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                S_INTERP: begin
                    // Native channel accumulates too; its sum is simply never written.
                    acc_r <= acc_r + {2'b00, rdata_r};
                    acc_g <= acc_g + {2'b00, rdata_g};
                    acc_b <= acc_b + {2'b00, rdata_b};
                    k     <= k + 2'd1;
                end
                S_LOAD, S_SAVE: begin
                    if (state == S_SAVE) begin
                        acc_r <= '0;
                        acc_g <= '0;
                        acc_b <= '0;
                    end
                    if (pix_last) begin
                        x <= '0;
                        y <= '0;
                        n <= '0;
                    end else begin
                        n <= n + ONE;
                        if (x_last) begin
                            x <= '0;
                            y <= y + H_BITS'(1);
                        end else begin
                            x <= x + W_BITS'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
